// File: rtl/merge4_pkg.sv
// Shared definitions for the 4:1 round-robin merge: channel count, default
// data width and the 2-bit channel index type used for ptr and out_sel.
package merge4_pkg;

  localparam int NUM_CH    = 4;
  localparam int DEF_WIDTH = 8;

  typedef logic [1:0] ch_idx_t;

  // Round-robin successor; 3 wraps to 0 through the 2-bit type.
  function automatic ch_idx_t next_ch(input ch_idx_t c);
    return c + ch_idx_t'(1);
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational round-robin arbiter: searches req upward from ptr (mod 4)
// and grants the first requester as one-hot, encoded index and any-flag.
module rr_arb4
  import merge4_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  ch_idx_t           ptr,
  output logic [NUM_CH-1:0] grant,
  output ch_idx_t           idx,
  output logic              any
);

  // NOTE: every output gets a default before the search loop so no path
  // leaves a signal unassigned, which would infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Walk from the farthest offset down to ptr itself so the nearest
    // requester is the last to overwrite idx and therefore wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[ptr + ch_idx_t'(k)]) begin
        idx = ptr + ch_idx_t'(k);
        any = 1'b1;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_merge4.sv
// Four valid/ready sources merged round-robin into one registered sink.
// Holds the output register, the round-robin pointer and handshake gating.
module rr_merge4
  import merge4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [1:0]              out_sel,
  input  logic                    out_ready
);

  ch_idx_t           ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  ch_idx_t           out_sel_q, out_sel_d;

  logic [NUM_CH-1:0] arb_grant;
  ch_idx_t           arb_idx;
  logic              arb_any;
  logic              load_ok;
  logic              transfer;

  rr_arb4 u_arb (
    .req   (in_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // rst_n gates the handshake so no channel sees ready while reset is held.
  assign load_ok  = !out_valid_q || out_ready;
  assign transfer = rst_n && en && load_ok && arb_any;
  assign in_ready = transfer ? arb_grant : '0;

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (transfer) begin
      ptr_d       = next_ch(arb_idx);
      out_valid_d = 1'b1;
      out_data_d  = in_data[arb_idx*WIDTH +: WIDTH];
      out_sel_d   = arb_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_merge4.sv
// Directed bench for rr_merge4: stimulus pushes expected items into a
// scoreboard queue; a negedge monitor pops and compares each drained item.
module tb_rr_merge4;
  import merge4_pkg::*;

  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [3:0]       in_valid;
  logic [4*W-1:0]   in_data;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [1:0]       out_sel;
  logic             out_ready;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   sel;
  } item_t;

  item_t sb_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  rr_merge4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  task automatic push(input logic [W-1:0] d, input logic [1:0] s);
    item_t it;
    it.data = d;
    it.sel  = s;
    sb_q.push_back(it);
  endtask

  // Monitor: every item leaving the output register must match the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_item", {22'd0, out_sel, out_data}, 32'hFFFF_FFFF);
      end else begin
        item_t e;
        e = sb_q.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_sel",  32'(out_sel),  32'(e.sel));
      end
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    set_data(8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    tick();
    rst_n    = 1'b1;
    in_valid = 4'h0;
  endtask

  initial begin
    // Reset and single transfer on channel 0
    do_reset();
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_sel",  32'(out_sel),  32'h0);
    in_valid = 4'b0001;
    set_data(8'hA5, 8'h00, 8'h00, 8'h00);
    #1;
    check("t1_in_ready", 32'(in_ready), 32'b0001);
    push(8'hA5, 2'd0);
    tick();
    in_valid = 4'b0000;
    #1;
    check("t1_out_valid", 32'(out_valid), 32'h1);
    check("t1_in_ready_idle", 32'(in_ready), 32'h0);
    tick();

    // Full-rate rotation over all four channels
    do_reset();
    set_data(8'h10, 8'h20, 8'h30, 8'h40);
    in_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rot_in_ready", 32'(in_ready), 32'(4'b0001 << (i % 4)));
      if (i > 0) check("rot_out_valid", 32'(out_valid), 32'h1);
      push(8'(8'h10 * ((i % 4) + 1)), 2'(i % 4));
      tick();
    end
    in_valid = 4'h0;
    tick();

    // Backpressure: hold 8'h33 while all channels request
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    set_data(8'h33, 8'h20, 8'h30, 8'h40);
    #1;
    check("bp_load_ready", 32'(in_ready), 32'b0001);
    push(8'h33, 2'd0);
    tick();
    in_valid = 4'hF;
    set_data(8'h10, 8'h20, 8'h30, 8'h40);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready",  32'(in_ready),  32'h0);
      check("bp_out_valid", 32'(out_valid), 32'h1);
      check("bp_out_data",  32'(out_data),  32'h33);
      check("bp_out_sel",   32'(out_sel),   32'h0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'b0010);
    push(8'h20, 2'd1);
    tick();
    in_valid = 4'h0;
    tick();

    // Pointer wrap: ptr=3 with only channel 1, then ptr=3 with channels 0 and 3
    in_valid = 4'b0100;
    set_data(8'h55, 8'h20, 8'h30, 8'h66);
    #1;
    check("wrap_c2a", 32'(in_ready), 32'b0100);
    push(8'h30, 2'd2);
    tick();
    in_valid = 4'b0010;
    #1;
    check("wrap_c1", 32'(in_ready), 32'b0010);
    push(8'h20, 2'd1);
    tick();
    in_valid = 4'b0100;
    #1;
    check("wrap_c2b", 32'(in_ready), 32'b0100);
    push(8'h30, 2'd2);
    tick();
    in_valid = 4'b1001;
    #1;
    check("wrap_c3", 32'(in_ready), 32'b1000);
    push(8'h66, 2'd3);
    tick();
    #1;
    check("wrap_c0", 32'(in_ready), 32'b0001);
    push(8'h55, 2'd0);
    tick();
    in_valid = 4'h0;
    tick();

    // Enable low: no acceptance, ptr frozen at 1, held item still drains
    en       = 1'b0;
    in_valid = 4'hF;
    set_data(8'h10, 8'h20, 8'h30, 8'h40);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("en0_in_ready",  32'(in_ready),  32'h0);
      check("en0_out_valid", 32'(out_valid), 32'h0);
      tick();
    end
    en = 1'b1;
    #1;
    check("en1_resume", 32'(in_ready), 32'b0010);
    push(8'h20, 2'd1);
    tick();
    en = 1'b0;
    #1;
    check("en0_full_ready", 32'(in_ready), 32'h0);
    tick();
    check("en0_drained", 32'(out_valid), 32'h0);

    // Asynchronous reset while FULL discards the held item
    en        = 1'b1;
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    tick();
    in_valid = 4'h0;
    check("ar_full", 32'(out_valid), 32'h1);
    in_valid = 4'b0100;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'h0);
    check("ar_out_data",  32'(out_data),  32'h0);
    check("ar_out_sel",   32'(out_sel),   32'h0);
    check("ar_in_ready",  32'(in_ready),  32'h0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b0001;
    set_data(8'hA5, 8'h00, 8'h00, 8'h00);
    #1;
    check("ar_no_stale",   32'(out_valid), 32'h0);
    check("ar_first_acc",  32'(in_ready),  32'b0001);
    push(8'hA5, 2'd0);
    tick();
    in_valid = 4'h0;
    check("ar_reload", 32'(out_valid), 32'h1);
    tick();
    tick();
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
